// File: rtl/pixel_frame_source.sv
// Frame-based pixel generator: streams FRAME_W x FRAME_H pixels per start request.
// Define PIXEL_SRC_LFSR_EN to make pattern 11 an 8-bit LFSR; otherwise it aliases pattern 01.
module pixel_frame_source #(
  parameter int FRAME_W = 8,
  parameter int FRAME_H = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cfg_mode,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] seed,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [1:0] m_mode,
  output logic       m_sof,
  output logic       m_eol,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] X_LAST = 8'(FRAME_W - 1);
  localparam logic [7:0] Y_LAST = 8'(FRAME_H - 1);

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] pat_q, pat_d;
  logic [7:0] seed_q, seed_d;
  logic [7:0] pix;
  logic       send;

`ifdef PIXEL_SRC_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_nxt;

  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
`ifdef PIXEL_SRC_LFSR_EN
      lfsr_q  <= 8'h01;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
`ifdef PIXEL_SRC_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Handshake: a pixel moves on a rising edge where m_valid and m_ready are both
  // high; m_valid never drops and the payload never changes until that happens.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
`ifdef PIXEL_SRC_LFSR_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          mode_d  = cfg_mode;
          pat_d   = pattern_sel;
          seed_d  = seed;
`ifdef PIXEL_SRC_LFSR_EN
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
`endif
        end
      end
      S_SEND: begin
        if (m_ready) begin
          idx_d = idx_q + 8'd1;
`ifdef PIXEL_SRC_LFSR_EN
          lfsr_d = lfsr_nxt;
`endif
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + 8'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // idx_q tracks y*FRAME_W + x modulo 256 without a multiplier.
  always_comb begin
    pix = seed_q;
    case (pat_q)
      2'b00: pix = seed_q;
      2'b01: pix = seed_q + idx_q;
      2'b10: pix = {y_q[3:0], x_q[3:0]} ^ seed_q;
`ifdef PIXEL_SRC_LFSR_EN
      2'b11: pix = lfsr_q;
`else
      2'b11: pix = seed_q + idx_q;
`endif
      default: pix = seed_q;
    endcase
  end

  assign send        = (state_q == S_SEND);
  assign m_valid     = send;
  assign m_data      = send ? pix : 8'h00;
  assign m_mode      = send ? mode_q : 2'b00;
  assign m_sof       = send && (x_q == 8'h00) && (y_q == 8'h00);
  assign m_eol       = send && (x_q == X_LAST);
  assign busy        = (state_q == S_SEND) || (state_q == S_DONE);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule
